// File: rtl/reset_sequencer.sv
// ----------------------------------------------------------------------------
// reset_sequencer
//
// Purpose:
//    Generates a set of active-high reset outputs that are released one at a
//    time, in index order, once the clock source reports a stable lock.
//    The sequence restarts on a software reset request or when lock is lost.
//
// Parameters:
//    NUM_OUTS     number of sequenced reset outputs (1..16)
//    SYNC_STAGES  synchronizer depth for lock_a (>= 2)
//    LOCK_FILTER  consecutive synchronized lock cycles needed before release
//    STEP_DELAY   clocks between successive output releases
//    HOLD_CYCLES  minimum time all outputs stay asserted after an abort
//
// Ports:
//    clk      block clock, all logic on its rising edge
//    rst      asynchronous active-high reset
//    lock_a   asynchronous PLL/MMCM lock status
//    sw_rst   clk-synchronous software reset request (level or pulse)
//    rst_out  active-high resets, bit 0 released first
//    ready    high once every rst_out bit is released
//    state    current FSM state code (HOLD=0, WAIT_LOCK=1, RELEASE=2, RUN=3)
// ----------------------------------------------------------------------------
module reset_sequencer #(
   parameter int NUM_OUTS    = 4,
   parameter int SYNC_STAGES = 2,
   parameter int LOCK_FILTER = 16,
   parameter int STEP_DELAY  = 8,
   parameter int HOLD_CYCLES = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                lock_a,
   input  logic                sw_rst,
   output logic [NUM_OUTS-1:0] rst_out,
   output logic                ready,
   output logic [1:0]          state
);

   // Counter is sized for the largest terminal count so it can never wrap
   // inside any state.
   localparam int MAX_HL  = (HOLD_CYCLES > LOCK_FILTER) ? HOLD_CYCLES : LOCK_FILTER;
   localparam int MAX_ALL = (MAX_HL > STEP_DELAY) ? MAX_HL : STEP_DELAY;
   localparam int CNT_W   = $clog2(MAX_ALL) + 1;
   localparam int IDX_W   = (NUM_OUTS > 1) ? $clog2(NUM_OUTS) : 1;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_FILTER - 1);
   localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_DELAY - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_OUTS - 1);

   typedef enum logic [1:0] {
      HOLD      = 2'd0,
      WAIT_LOCK = 2'd1,
      RELEASE   = 2'd2,
      RUN       = 2'd3
   } state_t;

   // ------------------------------------------------------------------------
   // Lock synchronizer
   // ------------------------------------------------------------------------
   (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_reg;
   logic lock_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_reg[0] <= 1'b0;
      end else begin
         sync_reg[0] <= lock_a;
      end
   end

   generate
      for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               sync_reg[gi] <= 1'b0;
            end else begin
               sync_reg[gi] <= sync_reg[gi-1];
            end
         end
      end
   endgenerate

   assign lock_s = sync_reg[SYNC_STAGES-1];

   // ------------------------------------------------------------------------
   // Sequencer state
   // ------------------------------------------------------------------------
   state_t              state_reg,   state_next;
   logic [CNT_W-1:0]    cnt_reg,     cnt_next;
   logic [IDX_W-1:0]    idx_reg,     idx_next;
   logic [NUM_OUTS-1:0] rst_out_reg, rst_out_next;
   logic                ready_reg,   ready_next;

   // One-hot mask of the output currently being released. Clearing through
   // this mask (AND-NOT) keeps already released bits low and can only ever
   // drop the bit at idx, so release order is strictly by index.
   logic [NUM_OUTS-1:0] step_mask;

   generate
      for (genvar gi = 0; gi < NUM_OUTS; gi++) begin : g_mask
         assign step_mask[gi] = (idx_reg == IDX_W'(gi));
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= HOLD;
         cnt_reg     <= '0;
         idx_reg     <= '0;
         rst_out_reg <= '1;
         ready_reg   <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         idx_reg     <= idx_next;
         rst_out_reg <= rst_out_next;
         ready_reg   <= ready_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      idx_next     = idx_reg;
      rst_out_next = rst_out_reg;
      ready_next   = ready_reg;

      if (sw_rst) begin
         // Software abort wins over everything, including a release or a
         // lock loss on the same edge. Held high, it keeps cnt at zero so
         // the hold time is counted from its deassertion.
         state_next   = HOLD;
         cnt_next     = '0;
         idx_next     = '0;
         rst_out_next = '1;
         ready_next   = 1'b0;
      end else begin
         case (state_reg)
            HOLD: begin
               rst_out_next = '1;
               ready_next   = 1'b0;
               if (cnt_reg == HOLD_LAST) begin
                  state_next = WAIT_LOCK;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt_reg + CNT_W'(1);
               end
            end

            WAIT_LOCK: begin
               rst_out_next = '1;
               ready_next   = 1'b0;
               if (!lock_s) begin
                  cnt_next = '0;
               end else if (cnt_reg == LOCK_LAST) begin
                  state_next = RELEASE;
                  cnt_next   = '0;
                  idx_next   = '0;
               end else begin
                  cnt_next = cnt_reg + CNT_W'(1);
               end
            end

            RELEASE: begin
               if (!lock_s) begin
                  state_next   = WAIT_LOCK;
                  cnt_next     = '0;
                  idx_next     = '0;
                  rst_out_next = '1;
                  ready_next   = 1'b0;
               end else if (cnt_reg == STEP_LAST) begin
                  rst_out_next = rst_out_reg & ~step_mask;
                  cnt_next     = '0;
                  if (idx_reg == IDX_LAST) begin
                     state_next = RUN;
                     ready_next = 1'b1;
                  end else begin
                     idx_next = idx_reg + IDX_W'(1);
                  end
               end else begin
                  cnt_next = cnt_reg + CNT_W'(1);
               end
            end

            RUN: begin
               if (!lock_s) begin
                  state_next   = WAIT_LOCK;
                  cnt_next     = '0;
                  idx_next     = '0;
                  rst_out_next = '1;
                  ready_next   = 1'b0;
               end else begin
                  rst_out_next = '0;
                  ready_next   = 1'b1;
               end
            end
         endcase
      end
   end

   assign rst_out = rst_out_reg;
   assign ready   = ready_reg;
   assign state   = state_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// ----------------------------------------------------------------------------
// tb_reset_sequencer
//
// Directed bench for reset_sequencer with NUM_OUTS=3, SYNC_STAGES=2,
// LOCK_FILTER=4, STEP_DELAY=3, HOLD_CYCLES=5. Outputs are sampled 1 time
// unit after each rising clock edge. Expected values are hand-computed edge
// counts relative to the edge E0 at which lock_a is first captured.
// ----------------------------------------------------------------------------
module tb_reset_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       lock_a;
   logic       sw_rst;
   logic [2:0] rst_out;
   logic       ready;
   logic [1:0] state;

   int n_checks = 0;
   int n_fails  = 0;

   reset_sequencer #(
      .NUM_OUTS    (3),
      .SYNC_STAGES (2),
      .LOCK_FILTER (4),
      .STEP_DELAY  (3),
      .HOLD_CYCLES (5)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .lock_a  (lock_a),
      .sw_rst  (sw_rst),
      .rst_out (rst_out),
      .ready   (ready),
      .state   (state)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp)
         $display("check %s observed=%0h expected=%0h", tag, obs, exp);
      else begin
         n_fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [2:0] e_rst,
                          input logic e_rdy, input logic [1:0] e_st);
      chk({tag, ".rst_out"}, 16'(rst_out), 16'(e_rst));
      chk({tag, ".ready"},   16'(ready),   16'(e_rdy));
      chk({tag, ".state"},   16'(state),   16'(e_st));
   endtask

   // Called right after lock_a has been raised with the sync chain at zero
   // and the FSM in WAIT_LOCK (cnt=0); the next edge is E0.
   task automatic run_sequence(input string tag);
      tick(5);  chk_all({tag, "@E0+4"},  3'b111, 1'b0, 2'd1);
      tick(1);  chk_all({tag, "@E0+5"},  3'b111, 1'b0, 2'd2);
      tick(2);  chk_all({tag, "@E0+7"},  3'b111, 1'b0, 2'd2);
      tick(1);  chk_all({tag, "@E0+8"},  3'b110, 1'b0, 2'd2);
      tick(2);  chk_all({tag, "@E0+10"}, 3'b110, 1'b0, 2'd2);
      tick(1);  chk_all({tag, "@E0+11"}, 3'b100, 1'b0, 2'd2);
      tick(2);  chk_all({tag, "@E0+13"}, 3'b100, 1'b0, 2'd2);
      tick(1);  chk_all({tag, "@E0+14"}, 3'b000, 1'b1, 2'd3);
      tick(3);  chk_all({tag, "@run"},   3'b000, 1'b1, 2'd3);
   endtask

   initial begin
      rst    = 1'b1;
      lock_a = 1'b0;
      sw_rst = 1'b0;

      // Reset state
      #12;
      chk_all("reset", 3'b111, 1'b0, 2'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // HOLD lasts 5 edges after reset release
      tick(4);  chk_all("hold@4", 3'b111, 1'b0, 2'd0);
      tick(1);  chk_all("hold@5", 3'b111, 1'b0, 2'd1);

      // Nominal release sequence
      lock_a = 1'b1;
      run_sequence("nominal");

      // Lock loss in RUN: visible after SYNC_STAGES+1 edges
      lock_a = 1'b0;
      tick(2);  chk_all("lockloss@2", 3'b000, 1'b1, 2'd3);
      tick(1);  chk_all("lockloss@3", 3'b111, 1'b0, 2'd1);
      lock_a = 1'b1;
      run_sequence("relock");

      // One-cycle sw_rst pulse in RUN
      sw_rst = 1'b1;
      tick(1);
      sw_rst = 1'b0;
      chk_all("swpulse@A", 3'b111, 1'b0, 2'd0);
      for (int k = 1; k <= 4; k++) begin
         tick(1);
         chk_all($sformatf("swpulse@A+%0d", k), 3'b111, 1'b0, 2'd0);
      end
      tick(1);  chk_all("swpulse@A+5",  3'b111, 1'b0, 2'd1);
      tick(3);  chk_all("swpulse@A+8",  3'b111, 1'b0, 2'd1);
      tick(1);  chk_all("swpulse@A+9",  3'b111, 1'b0, 2'd2);
      tick(3);  chk_all("swpulse@A+12", 3'b110, 1'b0, 2'd2);
      tick(6);  chk_all("swpulse@A+18", 3'b000, 1'b1, 2'd3);

      // Lock glitch: lock_s high 3, low 1, then high; filter restarts
      lock_a = 1'b0;
      tick(3);  chk_all("glitch@drop", 3'b111, 1'b0, 2'd1);
      lock_a = 1'b1;
      for (int k = 0; k < 9; k++) begin
         tick(1);
         if (k == 2) lock_a = 1'b0;
         if (k == 3) lock_a = 1'b1;
         chk_all($sformatf("glitch@E0+%0d", k), 3'b111, 1'b0, 2'd1);
      end
      tick(1);  chk_all("glitch@E0+9",  3'b111, 1'b0, 2'd2);
      tick(3);  chk_all("glitch@E0+12", 3'b110, 1'b0, 2'd2);
      tick(2);  chk_all("glitch@E0+14", 3'b110, 1'b0, 2'd2);

      // sw_rst on the edge that would release rst_out[1]
      sw_rst = 1'b1;
      tick(1);  chk_all("swcollide", 3'b111, 1'b0, 2'd0);
      tick(2);  chk_all("swheld",    3'b111, 1'b0, 2'd0);
      sw_rst = 1'b0;
      tick(4);  chk_all("swheld@+4", 3'b111, 1'b0, 2'd0);
      tick(1);  chk_all("swheld@+5", 3'b111, 1'b0, 2'd1);

      // Short async rst pulse mid-RELEASE
      tick(4);  chk_all("arst@W+4", 3'b111, 1'b0, 2'd2);
      tick(3);  chk_all("arst@W+7", 3'b110, 1'b0, 2'd2);
      tick(1);
      #1;
      rst = 1'b1;
      #1;
      chk_all("arst@pulse", 3'b111, 1'b0, 2'd0);
      #1;
      rst = 1'b0;
      tick(4);  chk_all("arst@H4",  3'b111, 1'b0, 2'd0);
      tick(1);  chk_all("arst@H5",  3'b111, 1'b0, 2'd1);
      tick(4);  chk_all("arst@H9",  3'b111, 1'b0, 2'd2);
      tick(3);  chk_all("arst@H12", 3'b110, 1'b0, 2'd2);
      tick(6);  chk_all("arst@H18", 3'b000, 1'b1, 2'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_OUTS, default 4: number of sequenced reset outputs (1..16).
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on lock_a (>=2).
REQ-003 SHALL have parameter LOCK_FILTER, default 16: consecutive synchronized lock cycles required before release starts (>=1).
REQ-004 SHALL have parameter STEP_DELAY, default 8: clocks between successive output releases (>=1).
REQ-005 SHALL have parameter HOLD_CYCLES, default 8: minimum assert time after sw_rst (>=1).
REQ-006 SHALL have port clk, input, 1: single block clock; all logic on posedge clk.
REQ-007 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port lock_a, input, 1: asynchronous PLL/MMCM lock status.
REQ-009 SHALL have port sw_rst, input, 1: clk-synchronous software reset request, level or pulse.
REQ-010 SHALL have port rst_out, output, NUM_OUTS: active-high resets; bit 0 released first.
REQ-011 SHALL have port ready, output, 1: high when all rst_out are released.
REQ-012 SHALL have port state, output, 2: current FSM state code for status readback.

Function
REQ-013 SHALL pass lock_a through a SYNC_STAGES-deep flop chain (ASYNC_REG marked, init 0, async reset); lock_s = last stage.
REQ-014 SHALL implement FSM states HOLD=0, WAIT_LOCK=1, RELEASE=2, RUN=3; all outputs registered.
REQ-015 HOLD: all rst_out=1, ready=0; counter cnt increments each clock; at cnt==HOLD_CYCLES-1 -> WAIT_LOCK, cnt=0.
REQ-016 WAIT_LOCK: all rst_out=1; cnt increments while lock_s=1, clears to 0 on lock_s=0; at lock_s=1 and cnt==LOCK_FILTER-1 -> RELEASE, cnt=0, idx=0.
REQ-017 RELEASE: cnt increments each clock; at cnt==STEP_DELAY-1, rst_out[idx] clears on that edge, cnt=0, idx++; when idx==NUM_OUTS-1 releases -> RUN and ready=1 on the same edge.
REQ-018 RUN: all rst_out=0, ready=1; holds until abort.
REQ-019 Abort: sw_rst=1 in any state -> next edge all rst_out=1, ready=0, state HOLD, cnt=0, idx=0; re-entering HOLD while sw_rst stays high restarts the hold count.
REQ-020 Lock loss: lock_s=0 in RELEASE or RUN (sw_rst=0) -> next edge all rst_out=1, ready=0, state WAIT_LOCK, cnt=0, idx=0.
REQ-021 sw_rst SHALL take priority over lock loss and over a release occurring on the same edge.
REQ-022 Released outputs SHALL stay released (monotonic) until an abort; no output SHALL deassert out of index order.
REQ-023 cnt width SHALL be clog2(max(HOLD_CYCLES, LOCK_FILTER, STEP_DELAY))+1; no wrap possible within a state.
REQ-024 With NUM_OUTS=1, RELEASE SHALL release bit 0 and enter RUN after STEP_DELAY clocks.

Reset
REQ-025 rst=1 SHALL asynchronously force rst_out=all ones, ready=0, state=HOLD, cnt=0, idx=0, sync chain=0.
REQ-026 On rst deassertion the FSM SHALL begin the HOLD count on the first subsequent clock edge; rst mid-RELEASE or mid-RUN reasserts all outputs immediately, without waiting for clk.

Verification (NUM_OUTS=3, SYNC_STAGES=2, LOCK_FILTER=4, STEP_DELAY=3, HOLD_CYCLES=5)
REQ-027 Nominal: release rst, lock_a=1 from start, first sampled at edge E0 after HOLD exit -> rst_out[0] clears after E0+8, rst_out[1] after E0+11, rst_out[2] and ready=1 after E0+14; state reads 3.
REQ-028 Lock glitch: lock_s high 3 cycles, low 1, then high -> no release until 4 consecutive high cycles; rst_out stays 3'b111 throughout.
REQ-029 Lock loss in RUN: lock_a low -> rst_out=3'b111, ready=0, state=1 after SYNC_STAGES+1 edges; lock restored -> full sequence repeats with identical spacing.
REQ-030 sw_rst 1-cycle pulse in RUN -> next edge rst_out=3'b111, state=0 for 5 clocks, then WAIT_LOCK, then sequence again.
REQ-031 sw_rst asserted on the same edge as rst_out[1] release -> rst_out[1] does not clear; all outputs =1, state=0.
REQ-032 Async rst pulse shorter than one clk period mid-RELEASE -> rst_out=3'b111 immediately, state=0, full sequence restarts from HOLD.
